// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the streaming expression checker.
package expr_pkg;

    typedef enum logic [1:0] {
        S_EXP   = 2'd0,
        S_NUM   = 2'd1,
        S_CLOSE = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CC_DIGIT = 3'd0,
        CC_OP    = 3'd1,
        CC_LP    = 3'd2,
        CC_RP    = 3'd3,
        CC_OTHER = 3'd4
    } char_class_e;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_LP    = 8'h28;
    localparam logic [7:0] ASCII_RP    = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII -> character-class decoder.
// Parentheses are recognised only when EXPR_CHECKER_PAREN_EN is defined.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] in,
    output logic [2:0] cls
);

    // Map the incoming byte onto one of the token classes.
    always_comb begin
        cls = CC_OTHER;
        if ((in >= ASCII_0) && (in <= ASCII_9)) begin
            cls = CC_DIGIT;
        end else if ((in == ASCII_PLUS) || (in == ASCII_MINUS) ||
                     (in == ASCII_STAR) || (in == ASCII_SLASH)) begin
            cls = CC_OP;
`ifdef EXPR_CHECKER_PAREN_EN
        end else if (in == ASCII_LP) begin
            cls = CC_LP;
        end else if (in == ASCII_RP) begin
            cls = CC_RP;
`endif
        end else begin
            cls = CC_OTHER;
        end
    end

endmodule

// File: rtl/expr_checker.sv
// Streaming arithmetic-expression syntax checker with sticky error flag.
// Define EXPR_CHECKER_PAREN_EN to compile in parenthesis nesting support.
module expr_checker
    import expr_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_DEPTH  = 7,
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1),
    localparam int DCNT_W    = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth
);

    localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(MAX_DIGITS);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};

    logic [2:0]        cls_raw_s;
    char_class_e       cls_s;
    state_e            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              depth_zero_s;

`ifdef EXPR_CHECKER_PAREN_EN
    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
    logic [DEPTH_W-1:0] depth_q, depth_d;
`endif

    expr_char_class u_char_class (
        .in  (in),
        .cls (cls_raw_s)
    );

    assign cls_s = char_class_e'(cls_raw_s);

    // Next-state logic; on entry to S_ERR the counters keep their current values.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
`ifdef EXPR_CHECKER_PAREN_EN
        depth_d = depth_q;
`endif
        if (in_valid) begin
            case (state_q)
                S_EXP: begin
                    if (cls_s == CC_DIGIT) begin
                        state_d = S_NUM;
                        dcnt_d  = DCNT_ONE;
`ifdef EXPR_CHECKER_PAREN_EN
                    end else if ((cls_s == CC_LP) && (depth_q < DEPTH_MAX)) begin
                        depth_d = depth_q + DEPTH_ONE;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_NUM: begin
                    if ((cls_s == CC_DIGIT) && (dcnt_q < DCNT_MAX)) begin
                        dcnt_d = dcnt_q + DCNT_ONE;
                    end else if (cls_s == CC_OP) begin
                        state_d = S_EXP;
                        dcnt_d  = DCNT_ZERO;
`ifdef EXPR_CHECKER_PAREN_EN
                    end else if ((cls_s == CC_RP) && (depth_q != DEPTH_ZERO)) begin
                        state_d = S_CLOSE;
                        dcnt_d  = DCNT_ZERO;
                        depth_d = depth_q - DEPTH_ONE;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end
`ifdef EXPR_CHECKER_PAREN_EN
                S_CLOSE: begin
                    if (cls_s == CC_OP) begin
                        state_d = S_EXP;
                    end else if ((cls_s == CC_RP) && (depth_q != DEPTH_ZERO)) begin
                        depth_d = depth_q - DEPTH_ONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
`endif
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_ERR;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_EXP;
            dcnt_q  <= DCNT_ZERO;
`ifdef EXPR_CHECKER_PAREN_EN
            depth_q <= DEPTH_ZERO;
`endif
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
`ifdef EXPR_CHECKER_PAREN_EN
            depth_q <= depth_d;
`endif
        end
    end

`ifdef EXPR_CHECKER_PAREN_EN
    assign depth_zero_s = (depth_q == DEPTH_ZERO);
    assign depth        = depth_q;
`else
    assign depth_zero_s = 1'b1;
    assign depth        = {DEPTH_W{1'b0}};
`endif

    assign out = ((state_q == S_NUM) || (state_q == S_CLOSE)) && depth_zero_s;
    assign err = (state_q == S_ERR);

endmodule
